// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encodings for the serial arithmetic stages
package serial_adder_pkg;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_RUN  = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = STATE_IDLE,
        RUN  = STATE_RUN,
        DONE = STATE_DONE
    } state_e;

endpackage

// File: rtl/serial_adder_fa.sv
// rtl/serial_adder_fa.sv - combinational one-bit full-adder cell
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial N-bit adder, LSB first, one full-adder cell
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int            CW       = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e         state_q, state_d;
    logic [N-1:0]   a_sr_q, a_sr_d;
    logic [N-1:0]   b_sr_q, b_sr_d;
    logic [N-1:0]   sum_q, sum_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           fa_s, fa_c;
    logic [N-1:0]   s_msb;

    fa u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        s_msb   = '0;
        s_msb[N-1] = fa_s;

        case (state_q)
            RUN: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                sum_d   = (sum_q >> 1) | s_msb;
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cout_d  = fa_c;
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE falls back to IDLE otherwise
                if (start) begin
                    state_d = RUN;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed scoreboard bench for serial_adder at N=8, 2 and 1
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start2 = 1'b0, cin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;

    logic       start1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    serial_adder #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_adder #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );
    serial_adder #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    int checks = 0;
    int failures = 0;
    logic [8:0] sb8[$];
    logic [2:0] sb2[$];
    logic [1:0] sb1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done on the N=8 instance; cyc counts edges after the accept edge.
    task automatic wait_done8(output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            if (busy8 === 1'b1) busy_cnt++;
            tick();
            cyc++;
        end
    endtask

    task automatic pop8(input string tag);
        logic [8:0] exp;
        exp = (sb8.size() > 0) ? sb8.pop_front() : 9'h1xx;
        chk(tag, {cout8, sum8}, exp);
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic c);
        int cyc, bc;
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        sb8.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
        tick();
        start8 = 1'b0;
        a8 = $urandom; b8 = $urandom; cin8 = 1'($urandom);
        wait_done8(cyc, bc);
        chk({tag, "_lat"}, cyc, 8);
        chk({tag, "_busy"}, bc, 8);
        pop8({tag, "_res"});
        tick();
        chk({tag, "_pulse"}, done8, 1'b0);
        chk({tag, "_hold"}, {cout8, sum8}, {1'b0, a} + {1'b0, b} + {8'd0, c});
    endtask

    initial begin
        int cyc, bc, seen;
        logic [2:0] e2;
        logic [1:0] e1;

        rst = 1'b1;
        start8 = 1'b1;
        tick();
        tick();
        chk("rst_busy8", busy8, 1'b0);
        chk("rst_done8", done8, 1'b0);
        chk("rst_res8", {cout8, sum8}, 9'h000);
        chk("rst_res2", {busy2, done2, cout2, sum2}, 5'h00);
        chk("rst_res1", {busy1, done1, cout1, sum1}, 4'h0);
        start8 = 1'b0;
        rst = 1'b0;
        tick();

        // 1, 2: basic sums and carry out
        op8("t1", 8'h5A, 8'h3C, 1'b0);
        op8("t2a", 8'hFF, 8'h01, 1'b0);
        op8("t2b", 8'hFF, 8'hFF, 1'b1);

        // 3: start during RUN is ignored
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        sb8.push_back(9'h030);
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("t3_busy", busy8, 1'b1);
        cyc = 4;
        while (done8 !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        chk("t3_lat", cyc, 8);
        pop8("t3_res");
        tick();

        // 4: reset mid-run abandons the operation
        a8 = 8'h77; b8 = 8'h11; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_rst", {busy8, done8, cout8, sum8}, 11'h000);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 === 1'b1) seen++;
            tick();
        end
        chk("t4_nodone", seen, 0);
        op8("t4_re", 8'h01, 8'h01, 1'b0);

        // 5: start held high gives back-to-back operations
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
        sb8.push_back(9'h003);
        tick();
        wait_done8(cyc, bc);
        chk("t5_lat1", cyc, 8);
        pop8("t5_res1");
        a8 = 8'h80; b8 = 8'h80;
        sb8.push_back(9'h100);
        tick();
        chk("t5_busy", busy8, 1'b1);
        a8 = 8'h00; b8 = 8'h00;
        cyc = 1;
        while (done8 !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        chk("t5_gap", cyc, 9);
        pop8("t5_res2");
        start8 = 1'b0;
        tick();

        // 6: exhaustive sweeps at N=2 and N=1
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++) begin
                    a2 = 2'(a); b2 = 2'(b); cin2 = 1'(c); start2 = 1'b1;
                    e2 = 3'(a + b + c);
                    sb2.push_back(e2);
                    tick();
                    start2 = 1'b0;
                    cyc = 0;
                    while (done2 !== 1'b1 && cyc < 10) begin tick(); cyc++; end
                    chk($sformatf("n2_lat_%0d_%0d_%0d", a, b, c), cyc, 2);
                    chk($sformatf("n2_res_%0d_%0d_%0d", a, b, c), {cout2, sum2},
                        (sb2.size() > 0) ? sb2.pop_front() : 3'bxxx);
                end
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < 2; c++) begin
                    a1 = 1'(a); b1 = 1'(b); cin1 = 1'(c); start1 = 1'b1;
                    e1 = 2'(a + b + c);
                    sb1.push_back(e1);
                    tick();
                    start1 = 1'b0;
                    chk($sformatf("n1_busy_%0d_%0d_%0d", a, b, c), busy1, 1'b1);
                    cyc = 0;
                    while (done1 !== 1'b1 && cyc < 10) begin tick(); cyc++; end
                    chk($sformatf("n1_lat_%0d_%0d_%0d", a, b, c), cyc, 1);
                    chk($sformatf("n1_res_%0d_%0d_%0d", a, b, c), {cout1, sum1},
                        (sb1.size() > 0) ? sb1.pop_front() : 2'bxx);
                end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
